// File: rtl/cmos_capture_pack.sv
// Camera Y-stream capture: frame skipping, 4-pixel packing into 32-bit words,
// and line/frame geometry checking, all on the pixel clock.
module cmos_capture_pack #(
    parameter int IMG_HDISP   = 64,
    parameter int IMG_VDISP   = 48,
    parameter int SKIP_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    output logic [31:0] wr_data,
    output logic        wr_en,
    output logic        frame_start,
    output logic        frame_done,
    output logic        line_err,
    output logic        frame_err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SKIP   = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_ACTIVE = 2'd3;

    localparam logic [11:0] HD  = 12'(IMG_HDISP);
    localparam logic [11:0] VD  = 12'(IMG_VDISP);
    localparam logic [3:0]  SKL = 4'((SKIP_FRAMES == 0) ? 0 : SKIP_FRAMES - 1);

    logic [1:0]  state;
    logic        vs1;
    logic        hs1;
    logic [7:0]  d1;
    logic        vs1_d;
    logic        hs1_d;
    logic [3:0]  skip_cnt;
    logic [11:0] pix_cnt;
    logic [11:0] line_cnt;
    logic [1:0]  grp;
    logic [23:0] pack;
    logic        done_pend;

    logic        vs_rise;
    logic        hs_fall;
    logic [11:0] pix_inc;
    logic [11:0] line_inc;
    logic [31:0] pad_word;

    assign vs_rise  = vs1 & ~vs1_d;
    assign hs_fall  = ~hs1 & hs1_d;
    assign pix_inc  = (pix_cnt == 12'hfff) ? pix_cnt : pix_cnt + 12'd1;
    assign line_inc = (line_cnt == 12'hfff) ? line_cnt : line_cnt + 12'd1;

    // Only bytes already collected in this group survive; the rest read as zero.
    always_comb begin
        pad_word = 32'd0;
        unique case (grp)
            2'd1:    pad_word = {24'd0, pack[7:0]};
            2'd2:    pad_word = {16'd0, pack[15:0]};
            2'd3:    pad_word = {8'd0, pack[23:0]};
            default: pad_word = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs1   <= 1'b0;
            hs1   <= 1'b0;
            d1    <= 8'd0;
            vs1_d <= 1'b0;
            hs1_d <= 1'b0;
        end else begin
            vs1   <= cam_vsync;
            hs1   <= cam_href;
            d1    <= cam_data;
            vs1_d <= vs1;
            hs1_d <= hs1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            skip_cnt    <= 4'd0;
            pix_cnt     <= 12'd0;
            line_cnt    <= 12'd0;
            grp         <= 2'd0;
            pack        <= 24'd0;
            done_pend   <= 1'b0;
            wr_data     <= 32'd0;
            wr_en       <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            wr_en       <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= done_pend;
            done_pend   <= 1'b0;
            if (!enable) begin
                state      <= ST_IDLE;
                skip_cnt   <= 4'd0;
                grp        <= 2'd0;
                frame_done <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        skip_cnt <= 4'd0;
                        state    <= (SKIP_FRAMES == 0) ? ST_WAIT : ST_SKIP;
                    end
                    ST_SKIP: begin
                        if (vs_rise) begin
                            if (skip_cnt == SKL) begin
                                state <= ST_WAIT;
                            end else begin
                                skip_cnt <= skip_cnt + 4'd1;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (vs_rise) begin
                            frame_start <= 1'b1;
                            line_cnt    <= 12'd0;
                            pix_cnt     <= 12'd0;
                            grp         <= 2'd0;
                            state       <= ST_ACTIVE;
                        end
                    end
                    ST_ACTIVE: begin
                        if (vs_rise) begin
                            // A new frame always wins, even over a line in flight.
                            frame_start <= 1'b1;
                            if (line_cnt != 12'd0 && line_cnt != VD) begin
                                frame_err <= 1'b1;
                            end
                            if (hs1) begin
                                line_err <= 1'b1;
                            end
                            line_cnt <= 12'd0;
                            pix_cnt  <= 12'd0;
                            grp      <= 2'd0;
                        end else if (hs1) begin
                            pack[{grp, 3'b000} +: 8] <= d1;
                            grp     <= grp + 2'd1;
                            pix_cnt <= pix_inc;
                            if (grp == 2'd3) begin
                                wr_en   <= 1'b1;
                                wr_data <= {d1, pack};
                            end
                        end else if (hs_fall) begin
                            if (grp != 2'd0) begin
                                wr_en   <= 1'b1;
                                wr_data <= pad_word;
                            end
                            if (pix_cnt != HD) begin
                                line_err <= 1'b1;
                            end
                            if (line_cnt >= VD) begin
                                frame_err <= 1'b1;
                            end
                            // Done follows the line's last word, padded or not.
                            if (line_inc == VD && line_cnt != VD) begin
                                if (grp == 2'd0) begin
                                    frame_done <= 1'b1;
                                end else begin
                                    done_pend <= 1'b1;
                                end
                            end
                            line_cnt <= line_inc;
                            pix_cnt  <= 12'd0;
                            grp      <= 2'd0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
